// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// frame bit constants and the baud divisor helper.
package uart_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and a selectable overflow
// policy (discard the incoming word, or overwrite the oldest entry).
module sync_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int DROP_OLDEST = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;
  logic          do_pop;

  always_comb begin
    do_pop     = pop && !empty_q;
    wr_en      = 1'b0;
    overflow_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;

    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    if (push) begin
      if (!full_q || do_pop) begin
        wr_en = 1'b1;
      end else begin
        overflow_d = 1'b1;
        if (DROP_OLDEST != 0) begin
          wr_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;

    if (wr_en && !do_pop && !full_q) level_d = level_q + LVL_ONE;
    else if (do_pop && !wr_en)       level_d = level_q - LVL_ONE;

    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Head is read combinationally so a pop can load the shifter on the same edge.
  assign rdata    = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte strobes are queued in a FIFO and
// shifted out LSB first, one frame at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int DROP_OLDEST = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dat_en,
  input  logic [7:0]                  dat,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    bit_next;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          pop;
  logic          baud_tick;
  logic [7:0]    fifo_rdata;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH      (FIFO_DEPTH),
    .DROP_OLDEST(DROP_OLDEST)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (dat_en),
    .wdata   (dat),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .overflow(overflow)
  );

  assign baud_tick = (cnt_q == CNT_LAST);
  assign bit_next  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = STOP_BIT;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_next;
            tx_d  = shift_q[bit_next];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        // IDLE then spends one high cycle before the next frame may start.
        if (baud_tick) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
